// File: rtl/bmult_share_pkg.sv
// Shared widths, response FIFO entry type and ID width helper for the bmult_share scheduler.
package bmult_share_pkg;

  localparam int unsigned A_W      = 10;
  localparam int unsigned B_W      = 10;
  localparam int unsigned P_W      = 20;
  localparam int unsigned MAX_ID_W = 3;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [P_W-1:0]      p;
  } rsp_entry_t;

  // Requester index width, never below one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/Bmult10x10.sv
// Registered 10x10 unsigned multiplier, one cycle from a/b to p.
module Bmult10x10
  import bmult_share_pkg::*;
(
  input  logic           clk,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] p
);

  always_ff @(posedge clk) begin
    p <= P_W'(a) * P_W'(b);
  end

endmodule

// File: rtl/bmult_share_rr_arb.sv
// Round-robin arbiter: one-hot grant scanning from an internal pointer that advances past the winner on accept.
module bmult_share_rr_arb
  import bmult_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        valid,
  input  logic                      advance,
  output logic [NUM_REQ-1:0]        grant,
  output logic [id_w(NUM_REQ)-1:0]  grant_idx
);

  localparam int unsigned ID_W = id_w(NUM_REQ);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] scan_idx;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    scan_idx  = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && valid[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/bmult_share_sched.sv
// Shares one Bmult10x10 among NUM_REQ requesters; products return in issue order via a credited FWFT FIFO.
// Optional per-requester grant and stall counters when BMULT_SHARE_STATS_EN is defined.
module bmult_share_sched
  import bmult_share_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MULT_LAT   = 1,
  parameter int unsigned FIFO_DEPTH = 4
`ifdef BMULT_SHARE_STATS_EN
  ,
  parameter int unsigned STAT_W     = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*A_W-1:0]    req_a,
  input  logic [NUM_REQ*B_W-1:0]    req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [P_W-1:0]            rsp_p,
  output logic [id_w(NUM_REQ)-1:0]  rsp_id
`ifdef BMULT_SHARE_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_grants,
  output logic [STAT_W-1:0]         stat_stalls
`endif
);

  localparam int unsigned ID_W  = id_w(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + MULT_LAT + 2) + 1;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               credit_ok;
  logic               accept;
  logic [A_W-1:0]     a_arr [NUM_REQ];
  logic [B_W-1:0]     b_arr [NUM_REQ];
  logic [A_W-1:0]     op_a;
  logic [B_W-1:0]     op_b;
  logic [P_W-1:0]     mult_p;
  logic [MULT_LAT:0]  tag_valid;
  logic [ID_W-1:0]    tag_id [MULT_LAT+1];
  logic [CNT_W-1:0]   inflight;
  rsp_entry_t         fifo_mem [FIFO_DEPTH];
  rsp_entry_t         head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               push;
  logic               pop;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign a_arr[i] = req_a[i*A_W +: A_W];
    assign b_arr[i] = req_b[i*B_W +: B_W];
  end

  bmult_share_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid     (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Credit counts entries already queued plus every product still travelling down the tag pipe.
  always_comb begin
    inflight = '0;
    for (int unsigned s = 0; s <= MULT_LAT; s++) begin
      inflight = inflight + CNT_W'(tag_valid[s]);
    end
  end

  assign credit_ok = (fifo_count + inflight) < CNT_W'(FIFO_DEPTH);
  assign req_ready = grant & {NUM_REQ{credit_ok & !rst}};
  assign accept    = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= a_arr[grant_idx];
      op_b <= b_arr[grant_idx];
    end
  end

  Bmult10x10 u_mult (
    .clk (clk),
    .a   (op_a),
    .b   (op_b),
    .p   (mult_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
    end else begin
      tag_valid[0] <= accept;
      for (int unsigned s = 1; s <= MULT_LAT; s++) tag_valid[s] <= tag_valid[s-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= grant_idx;
    for (int unsigned s = 1; s <= MULT_LAT; s++) tag_id[s] <= tag_id[s-1];
  end

  // Tag pipe output qualifies the multiplier result; stale products are never pushed.
  assign push = tag_valid[MULT_LAT];
  assign pop  = rsp_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_mem[wr_ptr] <= '{id: MAX_ID_W'(tag_id[MULT_LAT]), p: mult_p};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && (fifo_count == CNT_W'(FIFO_DEPTH))));
  end

  assign head      = fifo_mem[rd_ptr];
  assign rsp_valid = (fifo_count != '0);
  assign rsp_p     = rsp_valid ? head.p : '0;
  assign rsp_id    = rsp_valid ? ID_W'(head.id) : '0;

`ifdef BMULT_SHARE_STATS_EN
  logic [STAT_W-1:0] grant_cnt [NUM_REQ];

  // Saturating counters: they stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      stat_stalls <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (grant_cnt[i] != '1)) grant_cnt[i] <= grant_cnt[i] + 1'b1;
      end
      if ((|req_valid) && !credit_ok && (stat_stalls != '1)) stat_stalls <= stat_stalls + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    assign stat_grants[i*STAT_W +: STAT_W] = grant_cnt[i];
  end
`endif

endmodule

// File: tb/tb_bmult_share_sched.sv
// Directed bench for bmult_share_sched; stats checks build when BMULT_SHARE_STATS_EN is defined.
module tb_bmult_share_sched;

  localparam int unsigned SW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [39:0] req_a;
  logic [39:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [19:0] rsp_p;
  logic [1:0]  rsp_id;
`ifdef BMULT_SHARE_STATS_EN
  logic [4*SW-1:0] stat_grants;
  logic [SW-1:0]   stat_stalls;
`endif

  int errors = 0;
  int checks = 0;
  int exp_p [4] = '{1000000, 1000, 1023, 1024};

  always #5 clk = ~clk;

  bmult_share_sched #(
    .NUM_REQ    (4),
    .MULT_LAT   (1),
    .FIFO_DEPTH (4)
`ifdef BMULT_SHARE_STATS_EN
    ,
    .STAT_W     (SW)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_p       (rsp_p),
    .rsp_id      (rsp_id)
`ifdef BMULT_SHARE_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stalls (stat_stalls)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*10 +: 10] = 10'(a);
    req_b[i*10 +: 10] = 10'(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'b0000;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 4'b0000;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    cyc();
    cyc();

    // Reset state, ready gated by rst
    req_valid = 4'b0001;
    settle();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_p", 32'(rsp_p), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    req_valid = 4'b0000;
    rst = 1'b0;

    // 1: max operands, three-cycle latency, single beat
    set_op(0, 1023, 1023);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    settle();
    chk("t1_ready", 32'(req_ready), 1);
    cyc();
    req_valid = 4'b0000;
    settle();
    chk("t1_c1_valid", 32'(rsp_valid), 0);
    cyc();
    settle();
    chk("t1_c2_valid", 32'(rsp_valid), 0);
    cyc();
    settle();
    chk("t1_c3_valid", 32'(rsp_valid), 1);
    chk("t1_c3_p", 32'(rsp_p), 1046529);
    chk("t1_c3_id", 32'(rsp_id), 0);
    cyc();
    settle();
    chk("t1_c4_valid", 32'(rsp_valid), 0);

    // 2: all requesters busy, rotation and back-to-back responses
    do_reset();
    set_op(0, 1000, 1000);
    set_op(1, 200, 5);
    set_op(2, 31, 33);
    set_op(3, 2, 512);
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      settle();
      if (c < 8) chk("t2_ready", 32'(req_ready), 32'(1) << (c % 4));
      if (c >= 3 && c < 11) begin
        chk("t2_rsp_valid", 32'(rsp_valid), 1);
        chk("t2_rsp_id", 32'(rsp_id), 32'((c - 3) % 4));
        chk("t2_rsp_p", 32'(rsp_p), 32'(exp_p[(c - 3) % 4]));
      end
      if (c == 11) chk("t2_drained", 32'(rsp_valid), 0);
      cyc();
    end

    // 3: credit exhaustion with consumer stalled, then in-order drain
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      set_op(1, c + 1, 100);
      settle();
      chk("t3_ready", 32'(req_ready), (c < 4) ? 32'd2 : 32'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    set_op(1, 50, 100);
    settle();
    chk("t3_pop_no_credit", 32'(req_ready), 0);
    chk("t3_p0", 32'(rsp_p), 100);
    chk("t3_id0", 32'(rsp_id), 1);
    cyc();
    settle();
    chk("t3_resume", 32'(req_ready), 2);
    chk("t3_p1", 32'(rsp_p), 200);
    cyc();
    req_valid = 4'b0000;
    settle();
    chk("t3_p2", 32'(rsp_p), 300);
    cyc();
    settle();
    chk("t3_p3", 32'(rsp_p), 400);
    cyc();
    settle();
    chk("t3_p4", 32'(rsp_p), 5000);
    chk("t3_id4", 32'(rsp_id), 1);
    cyc();
    settle();
    chk("t3_empty", 32'(rsp_valid), 0);
    cyc();

    // 4: reset discards in-flight work and the pointer restarts at 0
    rsp_ready = 1'b1;
    set_op(0, 5, 5);
    set_op(1, 6, 6);
    set_op(3, 9, 9);
    req_valid = 4'b0001;
    settle();
    chk("t4_ready0", 32'(req_ready), 1);
    cyc();
    req_valid = 4'b0010;
    settle();
    chk("t4_ready1", 32'(req_ready), 2);
    cyc();
    rst = 1'b1;
    req_valid = 4'b1001;
    settle();
    chk("t4_rst_ready", 32'(req_ready), 0);
    cyc();
    rst = 1'b0;
    settle();
    chk("t4_after_rst_valid", 32'(rsp_valid), 0);
    chk("t4_ptr0_first", 32'(req_ready), 1);
    cyc();
    req_valid = 4'b1000;
    settle();
    chk("t4_c4_valid", 32'(rsp_valid), 0);
    chk("t4_ready3", 32'(req_ready), 8);
    cyc();
    req_valid = 4'b0000;
    settle();
    chk("t4_c5_valid", 32'(rsp_valid), 0);
    cyc();
    settle();
    chk("t4_r0_valid", 32'(rsp_valid), 1);
    chk("t4_r0_id", 32'(rsp_id), 0);
    chk("t4_r0_p", 32'(rsp_p), 25);
    cyc();
    settle();
    chk("t4_r1_id", 32'(rsp_id), 3);
    chk("t4_r1_p", 32'(rsp_p), 81);
    cyc();
    settle();
    chk("t4_empty", 32'(rsp_valid), 0);
    cyc();

    // 5: zero, power-of-two and unit products from one requester
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    set_op(2, 0, 517);
    settle();
    chk("t5_ready0", 32'(req_ready), 4);
    cyc();
    set_op(2, 512, 2);
    settle();
    chk("t5_ready1", 32'(req_ready), 4);
    cyc();
    set_op(2, 1, 1);
    settle();
    chk("t5_ready2", 32'(req_ready), 4);
    cyc();
    req_valid = 4'b0000;
    settle();
    chk("t5_p0", 32'(rsp_p), 0);
    chk("t5_v0", 32'(rsp_valid), 1);
    chk("t5_id0", 32'(rsp_id), 2);
    cyc();
    settle();
    chk("t5_p1", 32'(rsp_p), 1024);
    chk("t5_id1", 32'(rsp_id), 2);
    cyc();
    settle();
    chk("t5_p2", 32'(rsp_p), 1);
    chk("t5_id2", 32'(rsp_id), 2);
    cyc();
    settle();
    chk("t5_empty", 32'(rsp_valid), 0);
    cyc();

`ifdef BMULT_SHARE_STATS_EN
    // 6: grant and stall counters, then saturation
    do_reset();
    settle();
    chk("t6_rst_grants", 32'(stat_grants), 0);
    chk("t6_rst_stalls", 32'(stat_stalls), 0);
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    set_op(2, 3, 3);
    for (int c = 0; c < 7; c++) begin
      settle();
      cyc();
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    settle();
    cyc();
    req_valid = 4'b0100;
    settle();
    chk("t6_fifth_ready", 32'(req_ready), 4);
    cyc();
    req_valid = 4'b0000;
    settle();
    chk("t6_grants2", 32'(stat_grants[2*SW +: SW]), 5);
    chk("t6_grants0", 32'(stat_grants[0 +: SW]), 0);
    chk("t6_stalls", 32'(stat_stalls), 3);
    for (int c = 0; c < 6; c++) cyc();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    for (int c = 0; c < 15; c++) cyc();
    settle();
    chk("t6_grants_15", 32'(stat_grants[2*SW +: SW]), 15);
    for (int c = 0; c < 5; c++) cyc();
    settle();
    chk("t6_grants_sat", 32'(stat_grants[2*SW +: SW]), 15);
    chk("t6_no_stalls", 32'(stat_stalls), 0);
    req_valid = 4'b0000;
    cyc();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
